// File: rtl/alu_pipe.sv
// alu_pipe: handshaked execution unit.
//
// A single-cycle ALU op is computed in one registered stage. An unsigned low-half multiply
// runs iteratively as shift-add, one multiplier bit per cycle.
//
// Parameters
//   WIDTH  operand/result width (power of two, >= 8)
//   SHW    shift-amount bits taken from b (derived, do not override)
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    input handshake for op, a, b
//   op [3:0]             operation code
//   a, b [WIDTH-1:0]     operands
//   out_valid/out_ready  output handshake for result, zero
//   result [WIDTH-1:0]   registered result
//   zero                 registered, result == 0
//   busy                 multiply in progress
module alu_pipe #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy
);

  localparam int unsigned CW = SHW + 1;

  localparam logic [3:0] OpAdd  = 4'd0;
  localparam logic [3:0] OpSub  = 4'd1;
  localparam logic [3:0] OpAnd  = 4'd2;
  localparam logic [3:0] OpOr   = 4'd3;
  localparam logic [3:0] OpXor  = 4'd4;
  localparam logic [3:0] OpSll  = 4'd5;
  localparam logic [3:0] OpSrl  = 4'd6;
  localparam logic [3:0] OpSra  = 4'd7;
  localparam logic [3:0] OpSlt  = 4'd8;
  localparam logic [3:0] OpSltu = 4'd9;
  localparam logic [3:0] OpJalr = 4'd10;
  localparam logic [3:0] OpMul  = 4'd11;

  typedef enum logic [1:0] {StIdle, StMul, StHold} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             out_valid_q, out_valid_d;

  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] acc_next;
  logic [SHW-1:0]   shamt;
  logic             slot_free;
  logic             accept;

  // Single-cycle ALU; MUL and illegal codes yield 0 here.
  always_comb begin
    alu_res = '0;
    shamt   = b[SHW-1:0];
    sum     = a + b;
    case (op)
      OpAdd:   alu_res = sum;
      OpSub:   alu_res = a - b;
      OpAnd:   alu_res = a & b;
      OpOr:    alu_res = a | b;
      OpXor:   alu_res = a ^ b;
      OpSll:   alu_res = a << shamt;
      OpSrl:   alu_res = a >> shamt;
      OpSra:   alu_res = $signed(a) >>> shamt;
      OpSlt:   alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OpSltu:  alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
      OpJalr:  alu_res = sum & {{(WIDTH-1){1'b1}}, 1'b0};
      default: alu_res = '0;
    endcase
  end

  assign acc_next  = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  assign slot_free = !out_valid_q || out_ready;
  // Gated by rst_n so the unit never advertises readiness while held in reset.
  assign in_ready  = rst_n && (state_q == StIdle) && slot_free;
  assign accept    = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    count_d     = count_q;
    result_d    = result_q;
    zero_d      = zero_q;
    out_valid_d = out_valid_q;

    // Consume; a load below in the same cycle overrides this.
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      StIdle: begin
        if (accept) begin
          if (op == OpMul) begin
            mcand_d  = a;
            mplier_d = b;
            acc_d    = '0;
            count_d  = CW'(WIDTH);
            state_d  = StMul;
          end else begin
            result_d    = alu_res;
            zero_d      = (alu_res == '0);
            out_valid_d = 1'b1;
          end
        end
      end
      StMul: begin
        acc_d    = acc_next;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        count_d  = count_q - CW'(1);
        if (count_q == CW'(1)) begin
          if (slot_free) begin
            result_d    = acc_next;
            zero_d      = (acc_next == '0);
            out_valid_d = 1'b1;
            state_d     = StIdle;
          end else begin
            // Product parks in acc_q until the old result drains.
            state_d = StHold;
          end
        end
      end
      StHold: begin
        if (slot_free) begin
          result_d    = acc_q;
          zero_d      = (acc_q == '0);
          out_valid_d = 1'b1;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      count_q     <= '0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign result    = result_q;
  assign zero      = zero_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q == StMul);

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe: a default 32-bit instance and an 8-bit instance.
module tb_alu_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, zero, busy;
  logic [3:0]  op;
  logic [31:0] a, b, result;

  logic        in_valid8, in_ready8, out_valid8, out_ready8, zero8, busy8;
  logic [3:0]  op8;
  logic [7:0]  a8, b8, result8;

  int total  = 0;
  int passed = 0;
  int n;
  logic ok;

  alu_pipe #(.WIDTH(32)) u_dut32 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .zero     (zero),
    .busy     (busy)
  );

  alu_pipe #(.WIDTH(8)) u_dut8 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid8),
    .in_ready (in_ready8),
    .op       (op8),
    .a        (a8),
    .b        (b8),
    .out_valid(out_valid8),
    .out_ready(out_ready8),
    .result   (result8),
    .zero     (zero8),
    .busy     (busy8)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b1;
    in_valid = 1'b0; op = '0; a = '0; b = '0; out_ready = 1'b1;
    in_valid8 = 1'b0; op8 = '0; a8 = '0; b8 = '0; out_ready8 = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_zero", zero, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 0);
    tick; tick;
    rst_n = 1'b1;
    #1 check("rdy_after_rst", in_ready, 1);

    // Reset in the middle of a multiply: no product may emerge afterwards.
    in_valid = 1'b1; op = 4'd11; a = 32'd3; b = 32'd5;
    tick;
    in_valid = 1'b0;
    repeat (4) tick;
    check("mid_mul_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 0);
    tick; tick;
    rst_n = 1'b1;
    #1 check("mid_rst_rdy", in_ready, 1);
    ok = 1'b1;
    repeat (40) begin
      tick;
      if (out_valid !== 1'b0) ok = 1'b0;
    end
    check("no_stale_product", ok, 1);

    // Back-to-back stream with out_ready held high.
    in_valid = 1'b1;
    op = 4'd0; a = 32'd7; b = 32'd5; tick;
    check("add_res", result, 32'd12);
    check("add_ov", out_valid, 1);
    check("add_rdy", in_ready, 1);
    op = 4'd1; a = 32'd3; b = 32'd5; tick;
    check("sub_res", result, 32'hFFFF_FFFE);
    check("sub_rdy", in_ready, 1);
    op = 4'd7; a = 32'h8000_0000; b = 32'd4; tick;
    check("sra_res", result, 32'hF800_0000);
    check("sra_rdy", in_ready, 1);
    op = 4'd9; a = 32'd1; b = 32'hFFFF_FFFF; tick;
    check("sltu_res", result, 32'd1);
    check("sltu_ov", out_valid, 1);
    op = 4'd5; a = 32'd1; b = 32'h25; tick;
    check("sll_res", result, 32'h20);
    op = 4'd10; a = 32'h1001; b = 32'd2; tick;
    check("jalr_res", result, 32'h1002);
    op = 4'd10; a = 32'hFFFF_0001; b = 32'd0; tick;
    check("jalr_hi_res", result, 32'hFFFF_0000);
    op = 4'd8; a = 32'hFFFF_FFFF; b = 32'd1; tick;
    check("slt_neg_res", result, 32'd1);
    op = 4'd8; a = 32'd1; b = 32'hFFFF_FFFF; tick;
    check("slt_pos_res", result, 32'd0);
    check("slt_pos_zero", zero, 1);
    op = 4'd15; a = 32'd5; b = 32'd5; tick;
    check("illegal_res", result, 32'd0);
    check("illegal_zero", zero, 1);
    op = 4'd1; a = 32'd5; b = 32'd5; tick;
    check("sub0_res", result, 32'd0);
    check("sub0_zero", zero, 1);
    op = 4'd4; a = 32'hF0F0_F0F0; b = 32'hFF00_FF00; tick;
    check("xor_res", result, 32'h0FF0_0FF0);
    check("xor_zero", zero, 0);
    in_valid = 1'b0;
    tick;
    check("drain_ov", out_valid, 0);

    // Multiply latency and busy window.
    in_valid = 1'b1; op = 4'd11; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
    tick;
    in_valid = 1'b0;
    ok = (busy === 1'b1);
    for (int i = 1; i < 32; i++) begin
      tick;
      if (busy !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b0) ok = 1'b0;
    end
    check("mul_busy_window", ok, 1);
    tick;
    check("mul_ov_at_32", out_valid, 1);
    check("mul_res", result, 32'd1);
    check("mul_busy_done", busy, 0);
    tick;
    check("mul_consumed", out_valid, 0);

    // Backpressure: pending ADD blocks the MUL until it is consumed.
    out_ready = 1'b0;
    in_valid = 1'b1; op = 4'd0; a = 32'd1; b = 32'd2;
    tick;
    op = 4'd11; a = 32'd12345; b = 32'd6789;
    check("bp_add_res", result, 32'd3);
    #1 check("bp_rdy_low", in_ready, 0);
    tick; tick;
    check("bp_add_held", result, 32'd3);
    check("bp_add_ov", out_valid, 1);
    check("bp_mul_not_taken", busy, 0);
    out_ready = 1'b1;
    #1 check("bp_rdy_high", in_ready, 1);
    tick;
    in_valid = 1'b0; out_ready = 1'b0;
    check("bp_add_gone", out_valid, 0);
    check("bp_mul_busy", busy, 1);
    n = 0;
    do begin tick; n++; end while (out_valid !== 1'b1 && n < 40);
    check("bp_mul_latency", n, 32);
    check("bp_mul_res", result, 32'd83810205);
    repeat (3) tick;
    check("bp_prod_held", result, 32'd83810205);
    check("bp_prod_ov", out_valid, 1);
    out_ready = 1'b1;
    tick;
    check("bp_prod_taken", out_valid, 0);
    tick;
    check("bp_no_dup", out_valid, 0);

    // 8-bit instance.
    in_valid8 = 1'b1; op8 = 4'd11; a8 = 8'h10; b8 = 8'h10;
    tick;
    in_valid8 = 1'b0;
    n = 0;
    do begin tick; n++; end while (out_valid8 !== 1'b1 && n < 20);
    check("w8_mul_latency", n, 8);
    check("w8_mul_res", result8, 32'h00);
    check("w8_mul_zero", zero8, 1);
    in_valid8 = 1'b1; op8 = 4'd7; a8 = 8'h80; b8 = 8'd7;
    tick;
    check("w8_sra_res", result8, 32'hFF);
    op8 = 4'd13; a8 = 8'h12; b8 = 8'h34;
    tick;
    check("w8_illegal_res", result8, 32'h00);
    check("w8_illegal_zero", zero8, 1);
    op8 = 4'd5; a8 = 8'h01; b8 = 8'h09;
    tick;
    check("w8_sll_res", result8, 32'h02);
    op8 = 4'd11; a8 = 8'h0D; b8 = 8'h0B;
    tick;
    in_valid8 = 1'b0;
    n = 0;
    do begin tick; n++; end while (out_valid8 !== 1'b1 && n < 20);
    check("w8_mul2_latency", n, 8);
    check("w8_mul2_res", result8, 32'h8F);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
